// File: rtl/redmule_tcdm_splitter.sv
// Splits one wide HCI TCDM request into MP 32-bit bank requests and reassembles the
// per-lane responses in grant order. Optional traffic counters: REDMULE_TCDM_SPLIT_STATS_EN.
module redmule_tcdm_splitter #(
   parameter int unsigned DW    = 256,
   parameter int unsigned MP    = DW / 32,
   parameter int unsigned AW    = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req_i,
   output logic               gnt_o,
   input  logic [AW-1:0]      add_i,
   input  logic               wen_i,
   input  logic [DW/8-1:0]    be_i,
   input  logic [DW-1:0]      data_i,
   output logic               r_valid_o,
   output logic [DW-1:0]      r_data_o,
   output logic [MP-1:0]      n_req_o,
   input  logic [MP-1:0]      n_gnt_i,
   output logic [MP*AW-1:0]   n_add_o,
   output logic [MP-1:0]      n_wen_o,
   output logic [MP*4-1:0]    n_be_o,
   output logic [MP*32-1:0]   n_data_o,
   input  logic [MP-1:0]      n_r_valid_i,
   input  logic [MP*32-1:0]   n_r_data_i,
   output logic [31:0]        cnt_rd_o,
   output logic [31:0]        cnt_wr_o
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [MP-1:0] granted_q;
   logic [CW-1:0] out_cnt  [MP];
   logic [CW-1:0] fifo_cnt [MP];
   logic [PW-1:0] wr_ptr   [MP];
   logic [PW-1:0] rd_ptr   [MP];
   logic [31:0]   fifo_mem [MP][DEPTH];

   logic [MP-1:0] lane_hs, lane_ok, lane_rdy, fifo_empty, fifo_full;
   logic [MP-1:0] rsp_ok, push, pop;

   always_comb begin
      lane_hs    = '0;
      lane_ok    = '0;
      lane_rdy   = '0;
      fifo_empty = '0;
      fifo_full  = '0;
      rsp_ok     = '0;
      n_req_o    = '0;
      n_add_o    = '0;
      n_wen_o    = '0;
      n_be_o     = '0;
      n_data_o   = '0;
      r_data_o   = '0;
      for (int unsigned i = 0; i < MP; i++) begin
         n_add_o[i*AW +: AW] = add_i + AW'(4 * i);
         n_be_o[i*4 +: 4]    = be_i[i*4 +: 4];
         n_data_o[i*32 +: 32] = data_i[i*32 +: 32];
         n_wen_o[i]          = wen_i;
         n_req_o[i]          = req_i & ~granted_q[i] & (out_cnt[i] < CW'(DEPTH));
         lane_hs[i]          = n_req_o[i] & n_gnt_i[i];
         lane_ok[i]          = granted_q[i] | lane_hs[i];
         fifo_empty[i]       = (fifo_cnt[i] == '0);
         fifo_full[i]        = (fifo_cnt[i] == CW'(DEPTH));
         // a response only counts if a transaction is still waiting for it; this drops
         // stragglers from before a reset
         rsp_ok[i]           = n_r_valid_i[i] & (out_cnt[i] > fifo_cnt[i]);
         lane_rdy[i]         = ~fifo_empty[i] | rsp_ok[i];
         r_data_o[i*32 +: 32] = fifo_empty[i] ? n_r_data_i[i*32 +: 32] : fifo_mem[i][rd_ptr[i]];
      end
      gnt_o     = req_i & (&lane_ok);
      r_valid_o = &lane_rdy;
      push      = rsp_ok & ~(fifo_empty & {MP{r_valid_o}});
      pop       = ~fifo_empty & {MP{r_valid_o}};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         granted_q <= '0;
         for (int unsigned i = 0; i < MP; i++) begin
            out_cnt[i]  <= '0;
            fifo_cnt[i] <= '0;
            wr_ptr[i]   <= '0;
            rd_ptr[i]   <= '0;
         end
      end else begin
         granted_q <= gnt_o ? '0 : (granted_q | lane_hs);
         for (int unsigned i = 0; i < MP; i++) begin
            if (lane_hs[i] && !r_valid_o)
               out_cnt[i] <= out_cnt[i] + 1'b1;
            else if (!lane_hs[i] && r_valid_o)
               out_cnt[i] <= out_cnt[i] - 1'b1;
            if (push[i] && !pop[i])
               fifo_cnt[i] <= fifo_cnt[i] + 1'b1;
            else if (!push[i] && pop[i])
               fifo_cnt[i] <= fifo_cnt[i] - 1'b1;
            if (push[i])
               wr_ptr[i] <= (wr_ptr[i] == PW'(DEPTH - 1)) ? '0 : wr_ptr[i] + 1'b1;
            if (pop[i])
               rd_ptr[i] <= (rd_ptr[i] == PW'(DEPTH - 1)) ? '0 : rd_ptr[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < MP; i++)
         if (push[i]) fifo_mem[i][wr_ptr[i]] <= n_r_data_i[i*32 +: 32];
   end

`ifdef REDMULE_TCDM_SPLIT_STATS_EN
   logic [31:0] cnt_rd_q, cnt_wr_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_rd_q <= '0;
         cnt_wr_q <= '0;
      end else if (gnt_o) begin
         if (wen_i && cnt_rd_q != '1) cnt_rd_q <= cnt_rd_q + 1'b1;
         if (!wen_i && cnt_wr_q != '1) cnt_wr_q <= cnt_wr_q + 1'b1;
      end
   end

   assign cnt_rd_o = cnt_rd_q;
   assign cnt_wr_o = cnt_wr_q;
`else
   assign cnt_rd_o = '0;
   assign cnt_wr_o = '0;
`endif

   a_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni) (|granted_q) |-> req_i)
      else $error("wide request dropped before grant");
   a_fifo_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni) ~|(n_r_valid_i & fifo_full))
      else $error("lane response arrived with full buffer");

endmodule
